udp_port_demux: RTL and testbench
=================================

# udp_port_demux

Parametrised UDP receive-side port demultiplexer. It sits on the UDP frame output of the UDP block and steers each received frame to one of `M_COUNT` application channels. Steering matches the UDP destination port against a runtime-programmable port table. Frames whose port matches no enabled entry are dropped and counted. The payload path is generalised to `DATA_WIDTH` bits with optional `tkeep`.

## Interface

Parameters:
- `M_COUNT`, default 4: number of output channels (1–16).
- `DATA_WIDTH`, default 8: payload width in bits, a multiple of 8.
- `KEEP_ENABLE`, default `(DATA_WIDTH>8)`: carry `tkeep`. When 0, `tkeep` is ignored and driven all-ones.
- `KEEP_WIDTH`, default `DATA_WIDTH/8`: `tkeep` width.

Ports:
- `clk`  in  1  — clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  — reset. Synchronous, active-high.
- `cfg_port`  in  M_COUNT*16  — port table; entry i occupies `[16*i+:16]`.
- `cfg_port_en`  in  M_COUNT  — per-entry enable.
- `s_udp_hdr_valid` / `s_udp_hdr_ready`  in / out  1 / 1  — input header handshake.
- `s_udp_ip_source_ip`, `s_udp_ip_dest_ip`  in  32 each  — input IP addresses.
- `s_udp_source_port`, `s_udp_dest_port`, `s_udp_length`, `s_udp_checksum`  in  16 each  — input UDP header fields.
- `s_udp_payload_axis_tdata`  in  DATA_WIDTH  — input payload data.
- `s_udp_payload_axis_tkeep`  in  KEEP_WIDTH  — input payload byte enables.
- `s_udp_payload_axis_tvalid`, `s_udp_payload_axis_tlast`, `s_udp_payload_axis_tuser`  in  1 each  — input payload controls.
- `s_udp_payload_axis_tready`  out  1  — input payload ready.
- `m_udp_hdr_valid`  out  M_COUNT  — per-channel output header valid.
- `m_udp_hdr_ready`  in  M_COUNT  — per-channel output header ready.
- `m_udp_ip_source_ip`, `m_udp_ip_dest_ip`, `m_udp_source_port`, `m_udp_dest_port`, `m_udp_length`, `m_udp_checksum`  out  (same widths)  — registered header fields, shared by all channels.
- `m_udp_payload_axis_tdata` / `_tkeep` / `_tlast` / `_tuser`  out  shared  — payload, broadcast to all channels.
- `m_udp_payload_axis_tvalid`  out  M_COUNT  — per-channel payload valid.
- `m_udp_payload_axis_tready`  in  M_COUNT  — per-channel payload ready.
- `busy`  out  1  — high whenever state is not IDLE.
- `stat_drop`  out  1  — one-cycle pulse per dropped frame.
- `drop_count`  out  32  — saturating count of dropped frames.

## Operation

- States: IDLE, FORWARD, DROP.
- IDLE:
  - `s_udp_hdr_ready = !(|m_udp_hdr_valid)`.
  - Payload `tready` is 0.
- Header accept (valid&&ready in IDLE):
  - Selection: the lowest i with `cfg_port_en[i] && cfg_port[i]==s_udp_dest_port`.
  - On a match: register all header fields, set `m_udp_hdr_valid[i]`, latch `sel=i`, go to FORWARD.
  - On no match: go to DROP, pulse `stat_drop`, and increment `drop_count` (holds at 0xFFFFFFFF).
- The config inputs are sampled only at header accept. Changing them mid-frame has no effect on the frame in flight.
- `m_udp_hdr_valid[sel]` stays high until `m_udp_hdr_ready[sel]`. Header fields are stable while valid.
- FORWARD payload path is combinational pass-through:
  - `m_tvalid[sel] = s_tvalid`.
  - `s_tready = m_tready[sel]`.
  - The other channels' `tvalid` are 0.
  - data/keep/last/user pass straight through.
- DROP: `s_tready=1`; all beats are discarded; all `m_tvalid` are 0.
- FORWARD or DROP returns to IDLE on the input beat where `tvalid && tready && tlast`.
- A single-beat frame (tlast on its first beat) is legal and returns to IDLE after that one beat.
- Duplicate table entries resolve to the lowest index. An all-disabled table drops every frame.
- `tuser` is passed through unchanged. A frame with `tuser` set is still forwarded, not dropped.

## Timing

- Reset values:
  - state IDLE.
  - `m_udp_hdr_valid = 0`, `m_tvalid = 0`.
  - `s_udp_hdr_ready = 1` (first cycle after reset release).
  - `s_tready = 0`.
  - `busy = 0`, `stat_drop = 0`, `drop_count = 0`.
  - Header field registers = 0.
- Header latency: `m_udp_hdr_valid[sel]` rises 1 cycle after input header accept.
- `stat_drop` is high exactly in the cycle after an unmatched header accept. `drop_count` updates in the same cycle.
- The first payload beat can transfer 1 cycle after header accept, independent of output header acceptance.
- Payload latency is 0 cycles. No payload buffering.
- `s_udp_hdr_ready` falls the cycle after accept. It returns high the cycle after both the tlast transfer and the output header transfer have occurred.
- Back-to-back frames: the minimum gap is header accept at cycle N+1 after a tlast beat at cycle N.
- Reset mid-frame: the FSM returns to IDLE immediately. All valids drop in the same cycle as `rst`. Remaining beats of the aborted frame are held off (`tready=0`) until the next header is accepted.

## Test plan

- Table {5000, 5001, 5002, 5003}, all enabled; send a dest_port=5002 frame of 4 bytes 01 02 03 04 → channel 2 alone gets the header 1 cycle later and 4 beats with tlast on 04; channels 0, 1, 3 `tvalid` stay 0.
- dest_port=7000 (no match) → `s_tready=1` across all beats; `stat_drop` is a single pulse; `drop_count` goes 0→1; no `m_*_valid` asserted.
- Entries 1 and 3 both 6000; send dest 6000 → routed to channel 1. Clear `cfg_port_en[1]`, resend → routed to channel 3.
- Channel 0 `m_udp_hdr_ready=0` for 10 cycles while its payload completes → `s_udp_hdr_ready` stays 0 until the header transfer, then rises the next cycle; the second frame is accepted with no loss.
- Random `tvalid` and random per-channel `tready`, 200 frames of 1–64 bytes, `DATA_WIDTH=64` with `tkeep` → every byte, `tkeep`, `tlast`, `tuser` delivered in order on the correct channel.
- Assert `rst` for 1 cycle mid-payload → all outputs return to their reset values the next cycle; `drop_count=0`; a new frame is then forwarded correctly.

Source files
------------

// File: rtl/udp_port_demux.sv
// UDP receive-side port demultiplexer: steers each frame to one of M_COUNT
// channels by matching the UDP destination port against a programmable table.
module udp_port_demux #(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [M_COUNT*16-1:0]   cfg_port,
    input  logic [M_COUNT-1:0]      cfg_port_en,

    input  logic                    s_udp_hdr_valid,
    output logic                    s_udp_hdr_ready,
    input  logic [31:0]             s_udp_ip_source_ip,
    input  logic [31:0]             s_udp_ip_dest_ip,
    input  logic [15:0]             s_udp_source_port,
    input  logic [15:0]             s_udp_dest_port,
    input  logic [15:0]             s_udp_length,
    input  logic [15:0]             s_udp_checksum,
    input  logic [DATA_WIDTH-1:0]   s_udp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_udp_payload_axis_tkeep,
    input  logic                    s_udp_payload_axis_tvalid,
    output logic                    s_udp_payload_axis_tready,
    input  logic                    s_udp_payload_axis_tlast,
    input  logic                    s_udp_payload_axis_tuser,

    output logic [M_COUNT-1:0]      m_udp_hdr_valid,
    input  logic [M_COUNT-1:0]      m_udp_hdr_ready,
    output logic [31:0]             m_udp_ip_source_ip,
    output logic [31:0]             m_udp_ip_dest_ip,
    output logic [15:0]             m_udp_source_port,
    output logic [15:0]             m_udp_dest_port,
    output logic [15:0]             m_udp_length,
    output logic [15:0]             m_udp_checksum,
    output logic [DATA_WIDTH-1:0]   m_udp_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_udp_payload_axis_tkeep,
    output logic [M_COUNT-1:0]      m_udp_payload_axis_tvalid,
    input  logic [M_COUNT-1:0]      m_udp_payload_axis_tready,
    output logic                    m_udp_payload_axis_tlast,
    output logic                    m_udp_payload_axis_tuser,

    output logic                    busy,
    output logic                    stat_drop,
    output logic [31:0]             drop_count
);

    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FORWARD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [1:0]         state_p0;
    logic [SEL_W-1:0]   sel_p0;
    logic [M_COUNT-1:0] hdr_valid_p0;
    logic [31:0]        src_ip_p0;
    logic [31:0]        dst_ip_p0;
    logic [15:0]        src_port_p0;
    logic [15:0]        dst_port_p0;
    logic [15:0]        length_p0;
    logic [15:0]        checksum_p0;
    logic               drop_pulse_p0;
    logic [31:0]        drop_cnt_p0;

    logic               match_hit;
    logic [SEL_W-1:0]   match_idx;
    logic               hdr_accept;
    logic               last_fire;

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (cfg_port_en[i] && cfg_port[16*i +: 16] == s_udp_dest_port) begin
                match_hit = 1'b1;
                match_idx = SEL_W'(i);
            end
        end
    end

    assign s_udp_hdr_ready = !rst && (state_p0 == ST_IDLE) && !(|hdr_valid_p0);
    assign hdr_accept      = s_udp_hdr_valid && s_udp_hdr_ready;
    assign last_fire       = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready
                             && s_udp_payload_axis_tlast;

    // Payload is a zero-latency pass-through; reset gates valids immediately.
    always_comb begin
        m_udp_payload_axis_tvalid = '0;
        s_udp_payload_axis_tready = 1'b0;
        if (!rst) begin
            case (state_p0)
                ST_FORWARD: begin
                    m_udp_payload_axis_tvalid[sel_p0] = s_udp_payload_axis_tvalid;
                    s_udp_payload_axis_tready         = m_udp_payload_axis_tready[sel_p0];
                end
                ST_DROP: begin
                    s_udp_payload_axis_tready = 1'b1;
                end
                default: begin
                    s_udp_payload_axis_tready = 1'b0;
                end
            endcase
        end
    end

    assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
    assign m_udp_payload_axis_tkeep = (KEEP_ENABLE != 0) ? s_udp_payload_axis_tkeep
                                                         : {KEEP_WIDTH{1'b1}};
    assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
    assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;

    // Stage p0: frame control, header registers and drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0      <= ST_IDLE;
            sel_p0        <= '0;
            hdr_valid_p0  <= '0;
            src_ip_p0     <= '0;
            dst_ip_p0     <= '0;
            src_port_p0   <= '0;
            dst_port_p0   <= '0;
            length_p0     <= '0;
            checksum_p0   <= '0;
            drop_pulse_p0 <= 1'b0;
            drop_cnt_p0   <= '0;
        end else begin
            drop_pulse_p0 <= 1'b0;
            hdr_valid_p0  <= hdr_valid_p0 & ~m_udp_hdr_ready;
            case (state_p0)
                ST_IDLE: begin
                    if (hdr_accept) begin
                        if (match_hit) begin
                            src_ip_p0               <= s_udp_ip_source_ip;
                            dst_ip_p0               <= s_udp_ip_dest_ip;
                            src_port_p0             <= s_udp_source_port;
                            dst_port_p0             <= s_udp_dest_port;
                            length_p0               <= s_udp_length;
                            checksum_p0             <= s_udp_checksum;
                            hdr_valid_p0[match_idx] <= 1'b1;
                            sel_p0                  <= match_idx;
                            state_p0                <= ST_FORWARD;
                        end else begin
                            drop_pulse_p0 <= 1'b1;
                            drop_cnt_p0   <= sat_inc(drop_cnt_p0);
                            state_p0      <= ST_DROP;
                        end
                    end
                end
                ST_FORWARD, ST_DROP: begin
                    if (last_fire) begin
                        state_p0 <= ST_IDLE;
                    end
                end
                default: begin
                    state_p0 <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_udp_hdr_valid    = rst ? '0 : hdr_valid_p0;
    assign m_udp_ip_source_ip = src_ip_p0;
    assign m_udp_ip_dest_ip   = dst_ip_p0;
    assign m_udp_source_port  = src_port_p0;
    assign m_udp_dest_port    = dst_port_p0;
    assign m_udp_length       = length_p0;
    assign m_udp_checksum     = checksum_p0;

    assign busy       = (state_p0 != ST_IDLE);
    assign stat_drop  = drop_pulse_p0;
    assign drop_count = drop_cnt_p0;

endmodule

// File: tb/tb_udp_port_demux.sv
// Randomized scoreboard bench for udp_port_demux (4 channels, 64-bit payload with tkeep).
module tb_udp_port_demux;

    localparam int M  = 4;
    localparam int DW = 64;
    localparam int KW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [M*16-1:0]   cfg_port = '0;
    logic [M-1:0]      cfg_port_en = '0;
    logic              s_hdr_valid = 1'b0;
    logic              s_hdr_ready;
    logic [31:0]       s_sip = '0, s_dip = '0;
    logic [15:0]       s_sp = '0, s_dp = '0, s_len = '0, s_ck = '0;
    logic [DW-1:0]     s_tdata = '0;
    logic [KW-1:0]     s_tkeep = '0;
    logic              s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic              s_tready;
    logic [M-1:0]      m_hdr_valid;
    logic [M-1:0]      m_hdr_ready = '1;
    logic [31:0]       m_sip, m_dip;
    logic [15:0]       m_sp, m_dp, m_len, m_ck;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [M-1:0]      m_tvalid;
    logic [M-1:0]      m_tready = '1;
    logic              m_tlast, m_tuser;
    logic              busy, stat_drop;
    logic [31:0]       drop_count;

    udp_port_demux #(.M_COUNT(M), .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW)) dut (
        .clk(clk), .rst(rst),
        .cfg_port(cfg_port), .cfg_port_en(cfg_port_en),
        .s_udp_hdr_valid(s_hdr_valid), .s_udp_hdr_ready(s_hdr_ready),
        .s_udp_ip_source_ip(s_sip), .s_udp_ip_dest_ip(s_dip),
        .s_udp_source_port(s_sp), .s_udp_dest_port(s_dp),
        .s_udp_length(s_len), .s_udp_checksum(s_ck),
        .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
        .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
        .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
        .m_udp_hdr_valid(m_hdr_valid), .m_udp_hdr_ready(m_hdr_ready),
        .m_udp_ip_source_ip(m_sip), .m_udp_ip_dest_ip(m_dip),
        .m_udp_source_port(m_sp), .m_udp_dest_port(m_dp),
        .m_udp_length(m_len), .m_udp_checksum(m_ck),
        .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
        .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
        .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
        .busy(busy), .stat_drop(stat_drop), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [31:0] sip, dip;
        logic [15:0] sp, dp, len, ck;
    } hdr_t;

    typedef struct {
        int          ch;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l, u;
    } beat_t;

    hdr_t        hdr_q[$];
    beat_t       beat_q[$];
    logic [7:0]  fbytes[$];
    logic [15:0] tbl_port[M];
    logic        tbl_en[M];
    int          checks = 0;
    int          errors = 0;
    int          exp_drops = 0;
    int          mon_drops = 0;
    bit          rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < M; i++) begin
            cfg_port[16*i +: 16] = tbl_port[i];
            cfg_port_en[i]       = tbl_en[i];
        end
    endtask

    // Reference routing: first enabled table entry holding the port, else drop.
    function automatic int model_chan(input logic [15:0] port);
        for (int i = 0; i < M; i++)
            if (tbl_en[i] && tbl_port[i] == port) return i;
        return -1;
    endfunction

    // Random per-channel readies when enabled.
    initial forever begin
        @(posedge clk); #1;
        if (rand_ready_en) begin
            m_hdr_ready = 4'($urandom);
            m_tready    = 4'($urandom) | 4'($urandom);
        end
    end

    // Monitor: every output transfer must match the head of the expectation queues.
    always @(negedge clk) begin
        if (rst) begin
            hdr_q.delete();
            beat_q.delete();
            mon_drops = 0;
        end else begin
            for (int i = 0; i < M; i++) begin
                if (m_hdr_valid[i] && m_hdr_ready[i]) begin
                    checks++;
                    if (hdr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_hdr: channel %0d dest %0d, none expected", i, m_dp);
                    end else begin
                        hdr_t e;
                        e = hdr_q.pop_front();
                        if (e.ch != i || m_sip !== e.sip || m_dip !== e.dip || m_sp !== e.sp ||
                            m_dp !== e.dp || m_len !== e.len || m_ck !== e.ck) begin
                            errors++;
                            $display("FAIL hdr: ch %0d dp %0h sp %0h len %0h ck %0h sip %0h dip %0h expected ch %0d dp %0h sp %0h len %0h ck %0h sip %0h dip %0h",
                                     i, m_dp, m_sp, m_len, m_ck, m_sip, m_dip,
                                     e.ch, e.dp, e.sp, e.len, e.ck, e.sip, e.dip);
                        end
                    end
                end
                if (m_tvalid[i] && m_tready[i]) begin
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat: channel %0d data %0h, none expected", i, m_tdata);
                    end else begin
                        beat_t b;
                        b = beat_q.pop_front();
                        if (b.ch != i || m_tdata !== b.d || m_tkeep !== b.k ||
                            m_tlast !== b.l || m_tuser !== b.u) begin
                            errors++;
                            $display("FAIL beat: ch %0d d %0h k %0h l %0b u %0b expected ch %0d d %0h k %0h l %0b u %0b",
                                     i, m_tdata, m_tkeep, m_tlast, m_tuser, b.ch, b.d, b.k, b.l, b.u);
                        end
                    end
                end
            end
            if ($countones(m_tvalid) > 1) begin
                checks++;
                errors++;
                $display("FAIL tvalid_onehot: got %0b expected at most one bit", m_tvalid);
            end
            if (stat_drop) begin
                mon_drops++;
                check("drop_count_on_pulse", 64'(drop_count), 64'(mon_drops));
            end
        end
    end

    task automatic send_frame(input logic [15:0] port, input bit gaps, input int abort_after);
        int    ch, nb, n;
        beat_t beats[$];
        hdr_t  h;
        ch    = model_chan(port);
        h.ch  = ch;
        h.sip = $urandom; h.dip = $urandom;
        h.sp  = 16'($urandom); h.dp = port;
        h.len = 16'(fbytes.size() + 8); h.ck = 16'($urandom);
        nb = (fbytes.size() + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t bt;
            bt.ch = ch; bt.d = '0; bt.k = '0;
            for (int l = 0; l < 8; l++) begin
                if (b*8 + l < fbytes.size()) begin
                    bt.d[8*l +: 8] = fbytes[b*8 + l];
                    bt.k[l] = 1'b1;
                end
            end
            bt.l = (b == nb - 1);
            bt.u = 1'($urandom);
            beats.push_back(bt);
        end
        if (ch >= 0) begin
            hdr_q.push_back(h);
            foreach (beats[b]) beat_q.push_back(beats[b]);
        end
        s_sip = h.sip; s_dip = h.dip; s_sp = h.sp; s_dp = h.dp; s_len = h.len; s_ck = h.ck;
        s_hdr_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_hdr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_hdr_ready) begin
            check("hdr_accept_timeout", 64'(s_hdr_ready), 64'd1);
            s_hdr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        s_hdr_valid = 1'b0;
        if (ch < 0) exp_drops++;
        check("hdr_valid_latency", 64'(m_hdr_valid), (ch >= 0) ? 64'(1 << ch) : 64'd0);
        check("stat_drop_pulse", 64'(stat_drop), 64'(ch < 0));
        check("hdr_ready_fall", 64'(s_hdr_ready), 64'd0);
        check("busy_in_frame", 64'(busy), 64'd1);
        for (int b = 0; b < nb; b++) begin
            if (abort_after >= 0 && b >= abort_after) begin
                s_tdata = beats[b].d; s_tkeep = beats[b].k;
                s_tlast = beats[b].l; s_tuser = beats[b].u;
                s_tvalid = 1'b1;
                return;
            end
            if (gaps && ($urandom % 3 == 0)) begin
                s_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            s_tdata = beats[b].d; s_tkeep = beats[b].k;
            s_tlast = beats[b].l; s_tuser = beats[b].u;
            s_tvalid = 1'b1;
            @(negedge clk);
            if (ch < 0) begin
                check("drop_tready", 64'(s_tready), 64'd1);
                check("drop_no_tvalid", 64'(m_tvalid), 64'd0);
            end
            n = 0;
            while (!s_tready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (!s_tready) begin
                check("beat_timeout", 64'(s_tready), 64'd1);
                s_tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (ch < 0) begin
            check("stat_drop_single", 64'(stat_drop), 64'd0);
            check("drop_count_after", 64'(drop_count), 64'(exp_drops));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((hdr_q.size() != 0 || beat_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_hdr_q", 64'(hdr_q.size()), 64'd0);
        check("drain_beat_q", 64'(beat_q.size()), 64'd0);
    endtask

    task automatic set_table(input int p0, input int p1, input int p2, input int p3);
        tbl_port[0] = 16'(p0); tbl_port[1] = 16'(p1);
        tbl_port[2] = 16'(p2); tbl_port[3] = 16'(p3);
        for (int i = 0; i < M; i++) tbl_en[i] = 1'b1;
        apply_cfg();
    endtask

    initial begin
        set_table(5000, 5001, 5002, 5003);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hdr_ready", 64'(s_hdr_ready), 64'd1);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stat_drop", 64'(stat_drop), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_hdr_fields", {m_dp, m_sp, m_sip}, 64'd0);
        @(posedge clk); #1;

        // Basic forward to channel 2.
        fbytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(16'd5002, 1'b0, -1);
        // Unmatched port is dropped.
        fbytes.delete();
        for (int j = 0; j < 20; j++) fbytes.push_back(8'($urandom));
        send_frame(16'd7000, 1'b0, -1);
        check("first_drop_count", 64'(drop_count), 64'd1);
        drain();

        // Duplicate entries: lowest index, then next once disabled.
        set_table(5000, 6000, 5002, 6000);
        fbytes = '{8'hA1, 8'hA2, 8'hA3};
        send_frame(16'd6000, 1'b0, -1);
        drain();
        tbl_en[1] = 1'b0;
        apply_cfg();
        send_frame(16'd6000, 1'b0, -1);
        drain();

        // Hold channel 0 header ready low while its payload completes.
        set_table(5000, 5001, 5002, 5003);
        m_hdr_ready = 4'b1110;
        fbytes.delete();
        for (int j = 0; j < 16; j++) fbytes.push_back(8'(j + 16));
        send_frame(16'd5000, 1'b0, -1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("hold_hdr_ready_low", 64'(s_hdr_ready), 64'd0);
        end
        @(posedge clk); #1;
        m_hdr_ready = 4'b1111;
        @(negedge clk);
        check("hold_hdr_ready_xfer", 64'(s_hdr_ready), 64'd0);
        @(posedge clk); #1;
        check("hold_hdr_ready_rise", 64'(s_hdr_ready), 64'd1);
        check("hold_hdr_valid_clear", 64'(m_hdr_valid), 64'd0);
        send_frame(16'd5000, 1'b0, -1);
        drain();

        // Randomized traffic with random readies and valid gaps.
        rand_ready_en = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int nbytes;
            logic [15:0] port;
            nbytes = $urandom_range(1, 64);
            fbytes.delete();
            for (int j = 0; j < nbytes; j++) fbytes.push_back(8'($urandom));
            port = ($urandom % 5 == 0) ? 16'(7000 + $urandom % 8) : 16'(5000 + $urandom % 4);
            send_frame(port, 1'b1, -1);
        end
        drain();
        rand_ready_en = 1'b0;
        @(posedge clk); #1;
        m_hdr_ready = '1;
        m_tready    = '1;
        check("random_drop_total", 64'(drop_count), 64'(exp_drops));

        // Reset in the middle of a frame.
        fbytes.delete();
        for (int j = 0; j < 32; j++) fbytes.push_back(8'($urandom));
        send_frame(16'd5002, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_mid_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check("rst_mid_tready", 64'(s_tready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_drops = 0;
        @(negedge clk);
        check("post_rst_tready", 64'(s_tready), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_drop_count", 64'(drop_count), 64'd0);
        check("post_rst_hdr_ready", 64'(s_hdr_ready), 64'd1);
        check("post_rst_fields", {m_dp, m_len, m_ck}, 64'd0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        fbytes.delete();
        for (int j = 0; j < 12; j++) fbytes.push_back(8'($urandom));
        send_frame(16'd5001, 1'b1, -1);
        drain();
        check("final_drop_count", 64'(drop_count), 64'(exp_drops));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
